// File: rtl/round_robin_merge_2_if.sv
// Handshake bundle for the two-input merger: two upstream streams and one downstream stream with source tag.
interface round_robin_merge_2_if #(
  parameter int width = 8
);
  logic             up0_valid;
  logic             up0_ready;
  logic [width-1:0] up0_data;
  logic             up1_valid;
  logic             up1_ready;
  logic [width-1:0] up1_data;
  logic             down_valid;
  logic             down_ready;
  logic [width-1:0] down_data;
  logic             down_src;

  modport master (
    output up0_valid, up0_data, up1_valid, up1_data, down_ready,
    input  up0_ready, up1_ready, down_valid, down_data, down_src
  );

  modport slave (
    input  up0_valid, up0_data, up1_valid, up1_data, down_ready,
    output up0_ready, up1_ready, down_valid, down_data, down_src
  );
endinterface

// File: rtl/round_robin_merge_2.sv
// Two-input round-robin merger: per-input FIFOs feed one registered output; 2 cycles from input valid to output.
// Output stall freezes pops and priority; upk_ready = !full, or !full | pop when RR_MERGE_PUSH_ON_POP_EN is defined.
module round_robin_merge_2 #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input logic                  clk,
  input logic                  rst,
  round_robin_merge_2_if.slave bus
);
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [width-1:0] mem [2][depth];
  logic [aw-1:0]    wptr [2];
  logic [aw-1:0]    rptr [2];
  logic [cw-1:0]    cnt [2];
  logic [width-1:0] in_data [2];
  logic [1:0]       in_valid, full, empty, ready, push, pop, gnt;
  logic             slot_free, gnt_idx, last_grant;
  logic             out_valid, out_src;
  logic [width-1:0] out_data;

  assign in_valid   = {bus.up1_valid, bus.up0_valid};
  assign in_data[0] = bus.up0_data;
  assign in_data[1] = bus.up1_data;

  for (genvar k = 0; k < 2; k++) begin : g_flags
    assign full[k]  = (cnt[k] == full_cnt);
    assign empty[k] = (cnt[k] == '0);
  end

  // Reset forces readies low so no transfer is reported during the reset cycle.
`ifdef RR_MERGE_PUSH_ON_POP_EN
  assign ready = rst ? 2'b00 : (~full | pop);
`else
  assign ready = rst ? 2'b00 : ~full;
`endif

  assign push      = in_valid & ready;
  assign slot_free = !out_valid || bus.down_ready;

  always_comb begin
    gnt = 2'b00;
    if (slot_free && !rst) begin
      case (~empty)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign pop     = gnt;
  assign gnt_idx = gnt[1];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem[k][wptr[k]] <= in_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
        cnt[k]  <= '0;
      end
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wptr[k] <= wptr[k] + 1'b1;
        if (pop[k])  rptr[k] <= rptr[k] + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 1'b1;
          2'b01:   cnt[k] <= cnt[k] - 1'b1;
          default: cnt[k] <= cnt[k];
        endcase
      end
      // Priority only moves on a real grant; idle slots leave it alone.
      if (slot_free) begin
        if (|gnt) begin
          out_valid  <= 1'b1;
          out_data   <= mem[gnt_idx][rptr[gnt_idx]];
          out_src    <= gnt_idx;
          last_grant <= gnt_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.up0_ready  = ready[0];
  assign bus.up1_ready  = ready[1];
  assign bus.down_valid = out_valid;
  assign bus.down_data  = out_data;
  assign bus.down_src   = out_src;
endmodule

// File: tb/tb_round_robin_merge_2.sv
// Randomised and directed bench for round_robin_merge_2 with a queue-based reference model and output scoreboard.
module tb_round_robin_merge_2;
  localparam int width = 8;
  localparam int depth = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  round_robin_merge_2_if #(.width(width)) bus ();

  round_robin_merge_2 #(.width(width), .depth(depth)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-input word queues, an output-occupied flag and last winner.
  logic [width-1:0] mq0[$];
  logic [width-1:0] mq1[$];
  logic [8:0]       exp_q[$];
  logic [8:0]       got_q[$];
  logic             mv    = 1'b0;
  logic             mlast = 1'b1;
  bit               chk   = 1'b0;

  always @(posedge clk) begin : model
    logic r0, r1, free;
    logic [width-1:0] w;
    int g;
    if (rst) begin
      mq0.delete();
      mq1.delete();
      exp_q.delete();
      mv    = 1'b0;
      mlast = 1'b1;
      chk   = 1'b1;
    end else begin
      r0   = mq0.size() < depth;
      r1   = mq1.size() < depth;
      free = !mv || bus.down_ready;
      if (free) begin
        g = -1;
        if (mq0.size() > 0 && mq1.size() > 0) g = mlast ? 0 : 1;
        else if (mq0.size() > 0)              g = 0;
        else if (mq1.size() > 0)              g = 1;
        if (g == 0) begin
          w = mq0.pop_front();
          exp_q.push_back({1'b0, w});
          mv = 1'b1; mlast = 1'b0;
        end else if (g == 1) begin
          w = mq1.pop_front();
          exp_q.push_back({1'b1, w});
          mv = 1'b1; mlast = 1'b1;
        end else begin
          mv = 1'b0;
        end
      end
      if (bus.up0_valid && r0) mq0.push_back(bus.up0_data);
      if (bus.up1_valid && r1) mq1.push_back(bus.up1_data);
    end
  end

  // Monitor: per-cycle ready/valid checks and scoreboard pop on each output transfer.
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (chk) begin
      check("up0_ready", bus.up0_ready, (!rst && mq0.size() < depth));
      check("up1_ready", bus.up1_ready, (!rst && mq1.size() < depth));
      check("down_valid", bus.down_valid, mv);
      if (bus.down_valid && bus.down_ready && !rst) begin
        got_q.push_back({bus.down_src, bus.down_data});
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got src %0d data %0h, expected none", bus.down_src, bus.down_data);
        end else begin
          e = exp_q.pop_front();
          check("down_data", bus.down_data, e[7:0]);
          check("down_src", bus.down_src, e[8]);
        end
      end
    end
  end

  task automatic step(output logic a0, output logic a1);
    @(negedge clk);
    a0 = bus.up0_valid && bus.up0_ready;
    a1 = bus.up1_valid && bus.up1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a0, a1;
    for (int i = 0; i < n; i++) step(a0, a1);
  endtask

  task automatic send(input int n0, input logic [7:0] b0, input int n1, input logic [7:0] b1);
    int i0 = 0;
    int i1 = 0;
    logic a0, a1;
    for (int c = 0; c < 200 && (i0 < n0 || i1 < n1); c++) begin
      bus.up0_valid = (i0 < n0);
      bus.up0_data  = b0 + i0[7:0];
      bus.up1_valid = (i1 < n1);
      bus.up1_data  = b1 + i1[7:0];
      step(a0, a1);
      if (a0) i0++;
      if (a1) i1++;
    end
    bus.up0_valid = 1'b0;
    bus.up1_valid = 1'b0;
    check("send_done", {i0 == n0, i1 == n1}, 2'b11);
  endtask

  initial begin
    logic a0, a1;
    int acc;
    logic [8:0] e;
    logic [7:0] base;

    rst = 1'b1;
    bus.up0_valid = 1'b1; bus.up0_data = 8'h55;
    bus.up1_valid = 1'b1; bus.up1_data = 8'h66;
    bus.down_ready = 1'b0;
    idle(2);
    check("rst_down_valid", bus.down_valid, 1'b0);
    check("rst_down_data", bus.down_data, 8'h00);
    check("rst_down_src", bus.down_src, 1'b0);
    check("rst_up0_ready", bus.up0_ready, 1'b0);
    check("rst_up1_ready", bus.up1_ready, 1'b0);
    rst = 1'b0;
    bus.up0_valid = 1'b0;
    bus.up1_valid = 1'b0;
    idle(1);

    // Contention: first tie after reset goes to input 0, then strict alternation.
    got_q.delete();
    send(4, 8'h10, 4, 8'h20);
    bus.down_ready = 1'b1;
    idle(12);
    check("cont_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      base = (i % 2 == 0) ? 8'h10 : 8'h20;
      e = {1'(i % 2), base + 8'(i / 2)};
      check("cont_order", got_q[i], e);
    end

    // Single source on input 1.
    got_q.delete();
    send(0, 8'h00, 6, 8'hA0);
    idle(4);
    check("single_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      check("single_order", got_q[i], {1'b1, 8'hA0 + 8'(i)});

    // Backpressure: output holds first word, FIFO fills with depth more.
    bus.down_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.up0_valid = 1'b1;
      bus.up0_data  = 8'h30 + 8'(acc);
      step(a0, a1);
      if (a0) acc++;
    end
    bus.up0_valid = 1'b0;
    check("bp_accepts", acc, depth + 1);
    check("bp_hold_valid", bus.down_valid, 1'b1);
    check("bp_hold_data", bus.down_data, 8'h30);
    bus.down_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_on_rise", bus.up0_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_after", bus.up0_ready, 1'b1);
    @(posedge clk); #1;
    idle(8);

    // Priority hold: grant input 1, idle, then a tie must go to input 0.
    send(0, 8'h00, 1, 8'h40);
    idle(5);
    got_q.delete();
    send(1, 8'h50, 1, 8'h60);
    idle(5);
    check("prio_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("prio_first", got_q[0], {1'b0, 8'h50});
      check("prio_second", got_q[1], {1'b1, 8'h60});
    end

    // Mid-stream reset discards buffered and output words.
    bus.down_ready = 1'b0;
    send(3, 8'h70, 0, 8'h00);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mrst_down_valid", bus.down_valid, 1'b0);
    got_q.delete();
    bus.down_ready = 1'b1;
    idle(10);
    check("mrst_no_output", got_q.size(), 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.up0_valid  = ($urandom_range(0, 1) == 1);
      bus.up0_data   = 8'($urandom);
      bus.up1_valid  = ($urandom_range(0, 1) == 1);
      bus.up1_data   = 8'($urandom);
      bus.down_ready = ($urandom_range(0, 9) < 7);
      step(a0, a1);
    end

    bus.up0_valid  = 1'b0;
    bus.up1_valid  = 1'b0;
    bus.down_ready = 1'b1;
    idle(20);
    check("drain_exp_empty", exp_q.size(), 0);
    check("drain_fifos_empty", mq0.size() + mq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
